// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: streams one RAM frame per VS rising edge to a valid/ready byte sink
module frame_stream_ctrl #(
    parameter int         ADDR_W          = 15,
    parameter int         BYTES_PER_FRAME = 9216,
    parameter int         CNT_W           = 26,
    parameter int         PRE_WAIT        = 62500000,
    parameter int         POST_WAIT       = 62500000,
    parameter int         GAP_CYCLES      = 0,
    parameter int         RAM_LAT         = 1,
    parameter int         HEADER_EN       = 1,
    parameter logic [7:0] HDR0            = 8'hAA,
    parameter logic [7:0] HDR1            = 8'h55
) (
    input  logic              Clk,
    input  logic              i_Rst,
    input  logic              i_VS,
    input  logic              i_Mode,
    input  logic              i_Arm,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    output logic              o_Rd_En,
    input  logic [7:0]        i_Rd_Data,
    output logic [7:0]        o_Tx_Data,
    output logic              o_Tx_Valid,
    input  logic              i_Tx_Ready,
    output logic              o_Frame_Indicator,
    output logic              o_Busy,
    output logic              o_Drop,
    output logic [7:0]        o_Frame_Count
);
    typedef enum logic [2:0] {IDLE, PRE, HDR, FETCH, SEND, GAP, POST} state_t;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_WAIT - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_WAIT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BYTES_PER_FRAME - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [RAM_LAT-1:0] lat_sr;
    logic [ADDR_W-1:0]  addr_d;
    logic [7:0]         tx_data_d, fcnt_d;
    logic               vs_s1, vs_s2, vs_d, vs_rise, armed, arm_latch, arm_d;
    logic               hdr_sel, hdr_sel_d, rd_en_d, tx_valid_d, drop_d, accept;

    assign vs_rise = vs_s2 & ~vs_d;
    assign armed   = ~i_Mode | arm_latch;
    assign accept  = o_Tx_Valid & i_Tx_Ready;
    assign arm_d   = i_Arm | (arm_latch & ~(state == IDLE && vs_rise && armed));
    assign drop_d  = vs_rise & ((state != IDLE) | ~armed);

    // next-state and next-output values; the delay counter saturates and is zeroed on entry to each timed state
    always_comb begin
        state_d    = state;
        cnt_d      = (&cnt) ? cnt : cnt + 1'b1;
        addr_d     = o_Rd_Addr;
        rd_en_d    = 1'b0;
        tx_data_d  = o_Tx_Data;
        tx_valid_d = o_Tx_Valid;
        hdr_sel_d  = hdr_sel;
        fcnt_d     = o_Frame_Count;
        case (state)
            IDLE: if (vs_rise && armed) begin
                state_d = PRE;
                cnt_d   = '0;
            end
            PRE: if (cnt == PRE_LAST) begin
                cnt_d  = '0;
                addr_d = '0;
                if (HEADER_EN != 0) begin
                    state_d    = HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR0;
                    hdr_sel_d  = 1'b0;
                end else begin
                    state_d = FETCH;
                    rd_en_d = 1'b1;
                end
            end
            HDR: if (accept) begin
                if (!hdr_sel) begin
                    tx_data_d = HDR1;
                    hdr_sel_d = 1'b1;
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = FETCH;
                    rd_en_d    = 1'b1;
                end
            end
            FETCH: if (lat_sr[RAM_LAT-1]) begin
                tx_data_d  = i_Rd_Data;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: if (accept) begin
                tx_valid_d = 1'b0;
                cnt_d      = '0;
                if (o_Rd_Addr == ADDR_LAST) begin
                    state_d = POST;
                    addr_d  = '0;
                    fcnt_d  = o_Frame_Count + 8'd1;
                end else begin
                    addr_d = o_Rd_Addr + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else begin
                        state_d = FETCH;
                        rd_en_d = 1'b1;
                    end
                end
            end
            GAP: if (cnt == GAP_LAST) begin
                state_d = FETCH;
                rd_en_d = 1'b1;
            end
            POST: if (cnt == POST_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, synchroniser, read-latency tracker and registered outputs
    always_ff @(posedge Clk) begin
        if (i_Rst) begin
            state             <= IDLE;
            cnt               <= '0;
            lat_sr            <= '0;
            {vs_s1, vs_s2, vs_d} <= '0;
            arm_latch         <= 1'b0;
            hdr_sel           <= 1'b0;
            o_Rd_Addr         <= '0;
            o_Rd_En           <= 1'b0;
            o_Tx_Data         <= '0;
            o_Tx_Valid        <= 1'b0;
            o_Busy            <= 1'b0;
            o_Drop            <= 1'b0;
            o_Frame_Count     <= '0;
            o_Frame_Indicator <= 1'b1;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            lat_sr            <= (lat_sr << 1) | RAM_LAT'(o_Rd_En);
            {vs_s1, vs_s2, vs_d} <= {i_VS, vs_s1, vs_s2};
            arm_latch         <= arm_d;
            hdr_sel           <= hdr_sel_d;
            o_Rd_Addr         <= addr_d;
            o_Rd_En           <= rd_en_d;
            o_Tx_Data         <= tx_data_d;
            o_Tx_Valid        <= tx_valid_d;
            o_Busy            <= state != IDLE;
            o_Drop            <= drop_d;
            o_Frame_Count     <= fcnt_d;
            o_Frame_Indicator <= state == IDLE;
        end
    end
endmodule

// File: tb/tb_frame_stream_ctrl.sv
`timescale 1ns/1ps
// tb_frame_stream_ctrl: directed, table-driven and randomized checks of frame_stream_ctrl
module tb_frame_stream_ctrl;
    localparam int PRE = 5, POST = 3, GAP = 2, LAT = 2;

    typedef struct {
        bit mode;
        bit arm;
        bit mid_vs;
        bit rnd_rdy;
        bit exp_sent;
        int exp_drops;
    } vec_t;

    logic       clk = 0, rst = 1, vs = 0, mode = 0, arm = 0, rdy = 1;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, tx_data, fcnt;
    logic       rd_en, tx_valid, ind, busy, drop;

    int         checks = 0, errors = 0, cyc = 0, drops = 0, stall_left = 0, total_sent = 0;
    bit         rdy_rand = 0, stall_arm = 0, stall_taken = 0, arm_pending = 0;
    logic [7:0] fcnt_model = 0;
    logic [7:0] frame_exp [6] = '{8'hAA, 8'h55, 8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] acc_q [$];
    int         acc_t [$];
    logic [7:0] mem [16];
    logic [3:0] ra1 = 0, ra2 = 0;
    logic       re1 = 0, re2 = 0;
    logic       pv = 0, pa = 0, pr = 1;
    logic [7:0] pd = 0;
    vec_t       tbl [9];

    always #5 clk = ~clk;

    frame_stream_ctrl #(
        .ADDR_W(4), .BYTES_PER_FRAME(4), .CNT_W(8), .PRE_WAIT(PRE), .POST_WAIT(POST),
        .GAP_CYCLES(GAP), .RAM_LAT(LAT), .HEADER_EN(1), .HDR0(8'hAA), .HDR1(8'h55)
    ) dut (
        .Clk(clk), .i_Rst(rst), .i_VS(vs), .i_Mode(mode), .i_Arm(arm),
        .o_Rd_Addr(rd_addr), .o_Rd_En(rd_en), .i_Rd_Data(rd_data),
        .o_Tx_Data(tx_data), .o_Tx_Valid(tx_valid), .i_Tx_Ready(rdy),
        .o_Frame_Indicator(ind), .o_Busy(busy), .o_Drop(drop), .o_Frame_Count(fcnt)
    );

    // two-cycle-latency RAM; data is only meaningful for an enabled read
    always @(posedge clk) begin
        ra1 <= rd_addr;
        re1 <= rd_en;
        ra2 <= ra1;
        re2 <= re1;
    end
    assign rd_data = re2 ? mem[ra2] : 8'hEE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: log accepted bytes, count drop pulses, and require a stalled byte to stay put
    always @(negedge clk) begin
        if (!rst && !pr && pv && !pa) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, pd);
        end
        if (!rst && tx_valid && rdy) begin
            acc_q.push_back(tx_data);
            acc_t.push_back(cyc);
        end
        if (!rst && drop) drops++;
        pv = tx_valid;
        pa = tx_valid & rdy;
        pd = tx_data;
        pr = rst;
    end

    // sink ready: tied high, random, or a single 10-cycle stall on byte 8'h11
    initial forever begin
        @(posedge clk); #1;
        if (stall_arm && !stall_taken && tx_valid && tx_data == 8'h11) begin
            stall_taken = 1;
            stall_left  = 10;
        end
        rdy = (stall_left > 0) ? 1'b0 : rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall_left > 0) stall_left--;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_vs();
        tick();
        vs = 1;
        repeat (3) tick();
        vs = 0;
    endtask

    task automatic run_frame(input bit m, input bit a, input bit mid, input bit rnd,
                             input bit exp_sent, input int exp_drops);
        int base, d0, n;
        mode = m;
        rdy_rand = rnd;
        if (a) begin
            tick();
            arm = 1;
            tick();
            arm = 0;
            arm_pending = 1;
        end
        if (exp_sent) begin
            arm_pending = 0;
            fcnt_model++;
            total_sent++;
        end
        base = acc_q.size();
        d0 = drops;
        pulse_vs();
        if (exp_sent) begin
            if (mid) begin
                n = 0;
                while (acc_q.size() < base + 2 && n < 1000) begin tick(); n++; end
                pulse_vs();
            end
            n = 0;
            while ((acc_q.size() < base + 6 || !ind) && n < 3000) begin tick(); n++; end
            check("frame_done", n < 3000, 1);
        end else begin
            repeat (20) tick();
        end
        repeat (2) tick();
        check("byte_count", acc_q.size() - base, exp_sent ? 6 : 0);
        for (int i = 0; i < 6 && base + i < acc_q.size(); i++) check("byte", acc_q[base + i], frame_exp[i]);
        check("frame_cnt", fcnt, fcnt_model);
        check("drops", drops - d0, exp_drops);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int base, n, e0, last, ed;
        bit m, a, mv, rn, s;
        for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? 8'h10 + 8'(i) : 8'hE0;
        tbl = '{
            '{0, 0, 0, 0, 1, 0}, '{1, 0, 0, 0, 0, 1}, '{1, 1, 0, 0, 1, 0},
            '{1, 0, 0, 0, 0, 1}, '{0, 0, 1, 0, 1, 1}, '{0, 0, 0, 1, 1, 0},
            '{1, 1, 1, 1, 1, 1}, '{0, 1, 0, 0, 1, 0}, '{1, 0, 0, 0, 0, 1}
        };
        repeat (3) tick();
        check("rst_addr", rd_addr, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_fcnt", fcnt, 0);
        check("rst_ind", ind, 1);
        rst = 0;
        repeat (2) tick();

        // continuous frame with ready tied high: latency and spacing
        base = acc_q.size();
        tick();
        vs = 1;
        e0 = cyc;
        repeat (3) tick();
        check("busy_lag", busy, 0);
        tick();
        check("busy_rise", busy, 1);
        vs = 0;
        n = 0;
        while (acc_q.size() < base + 6 && n < 1000) begin tick(); n++; end
        check("t_bytes", acc_q.size() - base, 6);
        if (acc_q.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) check("t_byte", acc_q[base + i], frame_exp[i]);
            check("t_first", acc_t[base] + 1 - e0, 3 + PRE + 1);
            check("t_hdr_gap", acc_t[base + 1] - acc_t[base], 1);
            check("t_fetch", acc_t[base + 2] - acc_t[base + 1], LAT + 2);
            for (int k = 2; k < 5; k++) check("t_data_gap", acc_t[base + k + 1] - acc_t[base + k], GAP + LAT + 2);
            last = acc_t[base + 5] + 1;
            ed = 0;
            while (cyc < last + POST && ed < 100) begin tick(); ed++; end
            check("post_busy", ind, 0);
            tick();
            check("post_idle", ind, 1);
        end
        fcnt_model = 1;
        total_sent = 1;
        check("t_fcnt", fcnt, fcnt_model);

        // backpressure on 8'h11
        stall_arm = 1;
        run_frame(0, 0, 0, 0, 1, 0);
        check("stall_seen", stall_taken, 1);

        // table of mode / arm / mid-frame VS / ready scenarios
        for (int i = 0; i < 9; i++)
            run_frame(tbl[i].mode, tbl[i].arm, tbl[i].mid_vs, tbl[i].rnd_rdy, tbl[i].exp_sent, tbl[i].exp_drops);

        // reset while HDR1 is offered
        mode = 0;
        rdy_rand = 0;
        pulse_vs();
        n = 0;
        while (!(tx_valid && tx_data == 8'h55) && n < 200) begin tick(); n++; end
        check("saw_hdr1", tx_valid && tx_data == 8'h55, 1);
        rst = 1;
        tick();
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_addr", rd_addr, 0);
        check("mid_rst_fcnt", fcnt, 0);
        check("mid_rst_ind", ind, 1);
        rst = 0;
        fcnt_model = 0;
        arm_pending = 0;
        total_sent = 0;
        repeat (2) tick();
        run_frame(0, 0, 0, 0, 1, 0);

        // randomized scenarios against the arm/drop/frame model
        for (int r = 0; r < 30; r++) begin
            m  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 2) == 0);
            rn = 1'($urandom_range(0, 1));
            s  = !m || a || arm_pending;
            mv = s && ($urandom_range(0, 3) == 0);
            run_frame(m, a, mv, rn, s, (s ? 0 : 1) + (mv ? 1 : 0));
        end

        // frame counter wrap
        n = 0;
        do begin
            run_frame(0, 0, 0, 0, 1, 0);
            n++;
        end while (fcnt_model != 8'd0 && n < 400);
        check("wrap_cnt", fcnt, 0);
        check("wrap_frames", total_sent, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
